// File: rtl/led_pkg.sv
// Shared encodings, seed values and helpers for the LED pattern sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_SHL    = 2'd0,
    MODE_SHR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic [7:0] SEED_SHL   = 8'h01;
  localparam logic [7:0] SEED_SHR   = 8'h80;
  localparam logic [7:0] SEED_BLINK = 8'hFF;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Programmable prescaler: one-cycle tick every (DIV >> iSPEED) enabled cycles.
module led_tick_gen #(
  parameter int DIV   = 524288,
  parameter int CNT_W = 19
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iEN,
  input  logic [1:0] iSPEED,
  output logic       oTICK
);

  localparam logic [CNT_W:0]   DIV_V   = DIV[CNT_W:0];
  localparam logic [CNT_W:0]   LIM_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   lim;
  logic             tick;

  // >= rather than == so a speed-up past the current count ticks at once
  always_comb begin
    lim   = (DIV_V >> iSPEED) - LIM_ONE;
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (iEN) begin
      if ({1'b0, cnt_q} >= lim) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign oTICK = tick;

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: prescaled ticks or single steps advance a walk/bounce/blink pattern.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int DIV   = 524288,
  parameter int CNT_W = 19
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iRUN,
  input  logic       iSTEP,
  input  logic [1:0] iMODE,
  input  logic [1:0] iSPEED,
  output logic [7:0] oLED,
  output logic       oTICK
);

  mode_e      mode_q, mode_d, mode_in;
  logic       dir_q, dir_d;
  logic [7:0] led_q, led_d;
  logic       tick_q, tick_d;
  logic       tick, adv;

  led_tick_gen #(.DIV(DIV), .CNT_W(CNT_W)) u_tick (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iEN    (iRUN),
    .iSPEED (iSPEED),
    .oTICK  (tick)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mode_q <= MODE_SHL;
      dir_q  <= DIR_LEFT;
      led_q  <= SEED_SHL;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    mode_in = mode_e'(iMODE);
    adv     = iRUN ? tick : iSTEP;
    mode_d  = mode_q;
    dir_d   = dir_q;
    led_d   = led_q;
    tick_d  = adv;
    if (adv) begin
      mode_d = mode_in;
      // A mode change re-seeds instead of stepping
      if (mode_in != mode_q) begin
        unique case (mode_in)
          MODE_SHL:    led_d = SEED_SHL;
          MODE_SHR:    led_d = SEED_SHR;
          MODE_BOUNCE: begin led_d = SEED_SHL; dir_d = DIR_LEFT; end
          default:     led_d = SEED_BLINK;
        endcase
      end else begin
        unique case (mode_q)
          MODE_SHL:
            led_d = is_onehot(led_q) ? {led_q[6:0], led_q[7]} : SEED_SHL;
          MODE_SHR:
            led_d = is_onehot(led_q) ? {led_q[0], led_q[7:1]} : SEED_SHR;
          MODE_BOUNCE: begin
            if (!is_onehot(led_q)) begin
              led_d = SEED_SHL;
              dir_d = DIR_LEFT;
            end else if (dir_q == DIR_LEFT) begin
              if (led_q == 8'h80) begin
                led_d = 8'h40;
                dir_d = DIR_RIGHT;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q == 8'h01) begin
                led_d = 8'h02;
                dir_d = DIR_LEFT;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          default: begin
            if (led_q == 8'hFF)      led_d = 8'h00;
            else if (led_q == 8'h00) led_d = 8'hFF;
            else                     led_d = SEED_BLINK;
          end
        endcase
      end
    end
  end

  assign oLED  = led_q;
  assign oTICK = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with DIV=16.
module tb_led_pattern_ctrl;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic       iRUN;
  logic       iSTEP;
  logic [1:0] iMODE;
  logic [1:0] iSPEED;
  logic [7:0] oLED;
  logic       oTICK;

  int n_cmp = 0;
  int n_err = 0;

  led_pattern_ctrl #(.DIV(16), .CNT_W(4)) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iRUN   (iRUN),
    .iSTEP  (iSTEP),
    .iMODE  (iMODE),
    .iSPEED (iSPEED),
    .oLED   (oLED),
    .oTICK  (oTICK)
  );

  always #5 iCLK = ~iCLK;

  task automatic cyc(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0] run_seq [7]    = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] bounce_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    iRST_N = 1'b0; iRUN = 1'b1; iSTEP = 1'b0; iMODE = 2'd0; iSPEED = 2'd0;
    cyc(2);
    chk("reset_led", oLED, 8'h01);
    chk("reset_tick", {7'd0, oTICK}, 8'h00);

    // Run at base rate: first tick 16 edges after release
    iRST_N = 1'b1;
    cyc(15);
    chk("pre_first_tick_led", oLED, 8'h01);
    chk("pre_first_tick", {7'd0, oTICK}, 8'h00);
    cyc(1);
    chk("first_tick_led", oLED, 8'h02);
    chk("first_tick", {7'd0, oTICK}, 8'h01);
    for (int k = 0; k < 7; k++) begin
      cyc(15);
      chk("run_gap_tick", {7'd0, oTICK}, 8'h00);
      cyc(1);
      chk("run_tick", {7'd0, oTICK}, 8'h01);
      chk("run_led", oLED, run_seq[k]);
    end

    // Speed x8: tick every 2 cycles
    iSPEED = 2'd3;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("spd3_gap", {7'd0, oTICK}, 8'h00);
      cyc(1);
      chk("spd3_tick", {7'd0, oTICK}, 8'h01);
    end
    chk("spd3_led", oLED, 8'h08);

    // Speed change with count already past the new limit
    iSPEED = 2'd0;
    cyc(10);
    chk("cnt10_led", oLED, 8'h08);
    chk("cnt10_tick", {7'd0, oTICK}, 8'h00);
    iSPEED = 2'd2;
    cyc(1);
    chk("spdchg_tick", {7'd0, oTICK}, 8'h01);
    chk("spdchg_led", oLED, 8'h10);
    cyc(3);
    chk("spd2_gap", {7'd0, oTICK}, 8'h00);
    cyc(1);
    chk("spd2_tick", {7'd0, oTICK}, 8'h01);
    chk("spd2_led", oLED, 8'h20);
    cyc(4);
    chk("spd2_led2", oLED, 8'h40);

    // Bounce
    iSPEED = 2'd3;
    iMODE  = 2'd2;
    cyc(2);
    chk("bounce_seed", oLED, 8'h01);
    chk("bounce_seed_tick", {7'd0, oTICK}, 8'h01);
    for (int k = 0; k < 15; k++) begin
      cyc(2);
      chk("bounce_led", oLED, bounce_seq[k]);
    end

    // Pause, then back-to-back steps
    iRUN = 1'b0;
    cyc(100);
    chk("pause_led", oLED, 8'h02);
    chk("pause_tick", {7'd0, oTICK}, 8'h00);
    iSTEP = 1'b1;
    cyc(1);
    chk("step1_led", oLED, 8'h04);
    chk("step1_tick", {7'd0, oTICK}, 8'h01);
    cyc(1);
    chk("step2_led", oLED, 8'h08);
    cyc(1);
    chk("step3_led", oLED, 8'h10);
    chk("step3_tick", {7'd0, oTICK}, 8'h01);
    iSTEP = 1'b0;
    cyc(1);
    chk("step_done_led", oLED, 8'h10);
    chk("step_done_tick", {7'd0, oTICK}, 8'h00);

    // Step ignored while running; count resumes from frozen 0
    iRUN = 1'b1; iSTEP = 1'b1;
    cyc(1);
    chk("step_run_led", oLED, 8'h10);
    chk("step_run_tick", {7'd0, oTICK}, 8'h00);
    iSTEP = 1'b0;
    cyc(1);
    chk("resume_led", oLED, 8'h20);

    // Blink, then switch to SHR
    iMODE = 2'd3;
    cyc(2);
    chk("blink_seed", oLED, 8'hFF);
    cyc(2);
    chk("blink_off", oLED, 8'h00);
    cyc(2);
    chk("blink_on", oLED, 8'hFF);
    iMODE = 2'd1;
    cyc(2);
    chk("shr_seed", oLED, 8'h80);
    cyc(2);
    chk("shr_step", oLED, 8'h40);

    // Asynchronous reset between edges at count=7
    iSPEED = 2'd0;
    cyc(7);
    chk("pre_rst_led", oLED, 8'h40);
    #2;
    iRST_N = 1'b0;
    #1;
    chk("async_rst_led", oLED, 8'h01);
    chk("async_rst_tick", {7'd0, oTICK}, 8'h00);
    iMODE = 2'd0;
    cyc(1);
    iRST_N = 1'b1;
    cyc(15);
    chk("post_rst_gap_led", oLED, 8'h01);
    chk("post_rst_gap_tick", {7'd0, oTICK}, 8'h00);
    cyc(1);
    chk("post_rst_tick", {7'd0, oTICK}, 8'h01);
    chk("post_rst_led", oLED, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Sequencer for the 8-LED bank: a programmable tick prescaler drives a small pattern state machine that walks, bounces or blinks the LEDs. It replaces the free-running shift-with-wrap behaviour with run/pause, single-step, speed and mode control. It sits between the board switches and buttons (already synchronised and debounced upstream) and the LED pins.

## Interface
- DIV, default 524288: base tick period in iCLK cycles. Must be a power of two, ≥ 8.
- CNT_W, default 19: prescaler counter width. Must equal log2(DIV).
- iCLK  in  1  system clock; all state is updated on its rising edge.
- iRST_N  in  1  reset, asynchronous, active-low.
- iRUN  in  1  level; 1 = advance on ticks, 0 = paused.
- iSTEP  in  1  single-cycle pulse; while paused, advances exactly one step.
- iMODE  in  2  pattern select: 0 SHL, 1 SHR, 2 BOUNCE, 3 BLINK.
- iSPEED  in  2  tick period = DIV >> iSPEED cycles (×1, ×2, ×4, ×8 rate).
- oLED  out  8  LED drive, registered.
- oTICK  out  1  registered one-cycle pulse, asserted in the cycle oLED takes a new value.

## Operation
- **Reset values** (asynchronous, immediate on iRST_N low): oLED=0x01, oTICK=0, prescaler=0, direction=left, mode register=SHL.
- **Prescaler**
  - When iRUN=1, count up each cycle.
  - When the count reaches (DIV>>iSPEED)−1, raise an internal tick and clear the count to 0.
  - When iRUN=0, the count holds.
  - iSPEED may change at any time; the comparison uses ≥, so a count already past the new limit ticks on the next cycle.
- **Advance event** = tick (iRUN=1), or iSTEP=1 while iRUN=0. iSTEP is ignored while iRUN=1.
- **Mode register** updates only on an advance event. If iMODE differs from the stored mode, the advance re-seeds instead of stepping:
  - SHL → 0x01
  - SHR → 0x80
  - BOUNCE → 0x01, direction left
  - BLINK → 0xFF
- **Step rules** (iMODE unchanged):
  - SHL: rotate left. 0x80 → 0x01.
  - SHR: rotate right. 0x01 → 0x80.
  - BOUNCE: shift in the current direction. Reverse direction on reaching 0x80 (going left) or 0x01 (going right), so the sequence is 0x01,0x02,…,0x80,0x40,…,0x01,0x02.
  - BLINK: oLED ← ~oLED. Any value other than 0x00/0xFF is first forced to 0xFF.
- **Illegal value recovery:** if oLED is not one-hot in SHL/SHR/BOUNCE (e.g. after leaving BLINK), the step loads that mode's seed.

## Timing
- Advance event at cycle N → oLED and oTICK valid at N+1. oTICK is high for exactly that one cycle.
- Free-running tick spacing is exactly DIV>>iSPEED cycles, with no drift across ticks.
- iSTEP while paused → oLED changes at the next edge. Back-to-back iSTEP pulses give one step per cycle.
- iRUN 1→0 mid-count: the count is frozen. On 1 again, counting resumes from the frozen value; there is no reset and no extra tick.
- iRST_N low mid-operation: all outputs go to their reset values asynchronously. Counting restarts from 0 on the first edge after release.
- Mode change and tick in the same cycle: the re-seed wins; the seed is visible at N+1.

## Structure
- Shared package `led_pkg`:
  - mode encodings MODE_SHL/SHR/BOUNCE/BLINK
  - seed constants SEED_SHL=0x01, SEED_SHR=0x80, SEED_BLINK=0xFF
- Sub-module `led_tick_gen`:
  - parameters DIV, CNT_W
  - ports iCLK, iRST_N, iEN, iSPEED, oTICK
- Pattern state machine and mode/direction registers stay in the top module.

## Test plan
Bench uses DIV=16, CNT_W=4.
- **Reset/run:** hold iRST_N low, then release with iRUN=1, iMODE=0, iSPEED=0 → oLED 0x01 after reset; 0x02 sixteen cycles after release; 0x80→0x01 wrap after 8 ticks; oTICK pulses every 16 cycles.
- **Speed:** iSPEED=3 → ticks every 2 cycles. Switch iSPEED 0→2 when count=10 → tick on the next cycle, then every 4 cycles.
- **Bounce:** iMODE=2 → re-seed 0x01, then sequence 0x02…0x80,0x40…0x01,0x02 on successive ticks.
- **Pause/step:** iRUN=0 → oLED frozen for 100 cycles. Three iSTEP pulses → three single steps, each with oTICK. iSTEP with iRUN=1 → no extra step.
- **Blink/mode change:** iMODE=3 at tick → 0xFF, 0x00, 0xFF. Then iMODE=1 → 0x80 at next tick, then 0x40.
- **Async reset mid-count:** assert iRST_N between edges at count=7 → oLED=0x01 and oTICK=0 without waiting for an edge. After release, the first tick comes 16 cycles later.
